block_mm_sched: RTL and testbench
=================================

# block_mm_sched

Scheduler and operand sequencer for the 4x32 block matrix-multiply datapath (eight 4x4 systolic arrays plus reduction tree). For each job it:

- holds the datapath in reset while idle and releases it on `start`;
- reads four K-slices from operand memory;
- drives the diagonally skewed north/west feeds;
- waits for the datapath's `done`, captures the four result rows and presents them on a valid/ready output.

It sits between the tile-buffer/host logic and the datapath.

## Interface
Parameters:
- BIT_WIDTH, 16, element width (signed fixed point)
- FRAC_WIDTH, 8, fractional bits; passed through only, no arithmetic here

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  job request; accepted only in IDLE
- busy  out  1  high in every state except IDLE
- rd_en  out  1  operand memory read strobe; read data returns 1 cycle later
- rd_addr  out  2  K index within a group, 0..3
- a_rd_data  in  32*BIT_WIDTH  A column slice: group g at [g*4*BW +: 4*BW], row 0 in the MSB lane of the group
- b_rd_data  in  32*BIT_WIDTH  B row slice, same packing, column 0 in the MSB lane
- dp_rst_n  out  1  datapath synchronous reset
- west_in0..7, north_in0..7  out  4*BIT_WIDTH each  skewed feeds, lane 0 in the MSBs
- dp_row0..3  in  4*BIT_WIDTH  datapath result rows
- dp_done  in  1  datapath done
- res_row0..3  out  4*BIT_WIDTH  captured result
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- err  out  1  one-cycle timeout pulse (see Configuration)

## Operation
- States are IDLE, FEED, DRAIN, WAIT and OUT.
- IDLE:
  - dp_rst_n = 0, feeds are 0.
  - start = 1 moves to FEED.
- FEED, 4 cycles:
  - dp_rst_n = 1, rd_en = 1, rd_addr = 0,1,2,3.
  - Then go to DRAIN.
- DRAIN, 5 cycles:
  - rd_en = 0; skew lines flush.
  - Then go to WAIT.
- WAIT:
  - Wait for dp_done = 1.
  - On that cycle capture dp_row0..3 into res_row0..3, then go to OUT.
- OUT:
  - res_valid = 1 and dp_rst_n = 0.
  - res_row is held stable until res_valid && res_ready, then go to IDLE.
- Skew:
  - Lane r of every west/north port carries read element k delayed by r extra cycles.
  - A lane outputs 0 in any cycle where it has no valid element; skew registers clear when no valid element enters.
- start is ignored outside IDLE. dp_done is ignored outside WAIT.
- No arithmetic in this block; all data is passed through bit-exact.

## Timing
- Reset values:
  - All outputs are 0, including dp_rst_n = 0 and busy = 0.
  - Next state is IDLE. The WAIT counter clears.
- start sampled high in IDLE at cycle S:
  - FEED covers S+1..S+4.
  - rd_addr k is issued at S+1+k; data for k returns at S+2+k.
  - Lane r element k is driven during cycle S+3+k+r (last at S+9).
  - DRAIN covers S+5..S+9; WAIT starts at S+10.
- dp_rst_n goes high at S+1 and low on the first OUT cycle.
- If dp_done is seen at cycle D, then res_valid = 1 from D+1.
- res_valid drops the cycle after the handshake; start can be accepted in that same cycle (IDLE).
- rst_n low in any state, including mid-job: next cycle IDLE, all outputs at reset values, any captured result is discarded.

## Configuration
- Macro `BLOCK_MM_SCHED_TIMEOUT_EN`, defined:
  - A 5-bit counter runs in WAIT.
  - On the 31st WAIT cycle without dp_done: err = 1 for one cycle, go to IDLE (dp_rst_n = 0), no result is produced.
- Not defined:
  - No counter; WAIT persists until dp_done.
  - err is tied to 0.

## Structure
- Package block_mm_pkg:
  - state enum;
  - FEED_LEN = 4, DRAIN_LEN = 5, TIMEOUT_CYCLES = 31;
  - lane/group packing helper constants.
- Sub-module skew_line: parameterised delay DEPTH (0..3) with a valid bit that zeroes the output.
  - Instantiated once per lane: 8 groups x 4 lanes x 2 operands.

## Test plan
- Reset: hold rst_n low for 3 cycles → all outputs 0, dp_rst_n = 0, busy = 0.
- Skew: a_rd_data group 0 row r at rd_addr k = 16*r+k, start at S → west_in0 lane r equals 16*r+k exactly at S+3+k+r and is 0 elsewhere; same check on north.
- Full job with the real datapath: all A and B elements = 0x0100 (1.0) → every res_row element = 0x2000, res_valid asserted, busy = 1 until handshake.
- Backpressure: res_ready low for 10 cycles with start pulsed during OUT → res_row stable, start ignored, handshake returns to IDLE next cycle.
- Timeout, macro defined: dp_done tied 0 → err pulse on the 31st WAIT cycle, then IDLE with res_valid never asserted. Macro undefined: still in WAIT after 100 cycles.
- rst_n low for 1 cycle mid-WAIT → next cycle IDLE, dp_rst_n = 0, and a fresh job then completes correctly.

Source files
------------

// File: rtl/block_mm_pkg.sv
// Shared types and constants for the block matrix-multiply scheduler.
package block_mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_WAIT,
    S_OUT
  } state_t;

  localparam int FEED_LEN       = 4;
  localparam int DRAIN_LEN      = 5;
  localparam int TIMEOUT_CYCLES = 31;

  // Operand packing: GROUPS groups of LANES elements, lane 0 in the MSBs of a group.
  localparam int LANES  = 4;
  localparam int GROUPS = 8;

endpackage

// File: rtl/block_mm_sched_skew_line.sv
// One feed lane: DEPTH extra cycles of delay behind a capture register,
// with a valid bit that forces the output to zero when no element is in flight.
module skew_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] data_q [0:DEPTH];
  logic [DEPTH:0]   vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i <= DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_valid;
      data_q[0] <= in_valid ? in_data : '0;
      for (int i = 1; i <= DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= vld_q[i-1] ? data_q[i-1] : '0;
      end
    end
  end

  assign out_data = vld_q[DEPTH] ? data_q[DEPTH] : '0;

endmodule

// File: rtl/block_mm_sched.sv
// Job scheduler and skewed operand sequencer for the 4x32 block matmul datapath.
// Optional WAIT timeout is enabled by defining BLOCK_MM_SCHED_TIMEOUT_EN.
module block_mm_sched
  import block_mm_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      rd_en,
  output logic [1:0]                rd_addr,
  input  logic [32*BIT_WIDTH-1:0]   a_rd_data,
  input  logic [32*BIT_WIDTH-1:0]   b_rd_data,
  output logic                      dp_rst_n,
  output logic [4*BIT_WIDTH-1:0]    west_in0, west_in1, west_in2, west_in3,
  output logic [4*BIT_WIDTH-1:0]    west_in4, west_in5, west_in6, west_in7,
  output logic [4*BIT_WIDTH-1:0]    north_in0, north_in1, north_in2, north_in3,
  output logic [4*BIT_WIDTH-1:0]    north_in4, north_in5, north_in6, north_in7,
  input  logic [4*BIT_WIDTH-1:0]    dp_row0, dp_row1, dp_row2, dp_row3,
  input  logic                      dp_done,
  output logic [4*BIT_WIDTH-1:0]    res_row0, res_row1, res_row2, res_row3,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      err,
  output state_t                    state
);

  // FRAC_WIDTH only describes the data format; values pass through bit-exact.
  if (FRAC_WIDTH >= BIT_WIDTH) begin : g_frac_exceeds_width
  end

  // Handshake: res_row is valid while res_valid=1 and is consumed on the
  // cycle where res_valid && res_ready; the job then returns to IDLE.
  state_t     state_next;
  logic [2:0] phase_cnt;
  logic       rd_vld;
  logic       capture;
  logic       timeout_hit;

  logic [GROUPS-1:0][LANES-1:0][BIT_WIDTH-1:0] west_feed, north_feed;

`ifdef BLOCK_MM_SCHED_TIMEOUT_EN
  logic [4:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || state != S_WAIT) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + 5'd1;
  end

  assign timeout_hit = (state == S_WAIT) && !dp_done &&
                       (wait_cnt == 5'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_FEED;
      S_FEED:  if (phase_cnt == 3'(FEED_LEN - 1)) state_next = S_DRAIN;
      S_DRAIN: if (phase_cnt == 3'(DRAIN_LEN - 1)) state_next = S_WAIT;
      S_WAIT: begin
        if (dp_done)          state_next = S_OUT;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_OUT:   if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign capture   = (state == S_WAIT) && dp_done;
  assign busy      = (state != S_IDLE);
  assign rd_en     = (state == S_FEED);
  assign rd_addr   = phase_cnt[1:0];
  assign dp_rst_n  = (state == S_FEED) || (state == S_DRAIN) || (state == S_WAIT);
  assign res_valid = (state == S_OUT);
  assign err       = timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      rd_vld    <= 1'b0;
      res_row0  <= '0;
      res_row1  <= '0;
      res_row2  <= '0;
      res_row3  <= '0;
    end else begin
      state     <= state_next;
      phase_cnt <= (state_next != state) ? 3'd0 : phase_cnt + 3'd1;
      rd_vld    <= rd_en;
      if (capture) begin
        res_row0 <= dp_row0;
        res_row1 <= dp_row1;
        res_row2 <= dp_row2;
        res_row3 <= dp_row3;
      end
    end
  end

  // Lane r carries r extra cycles of skew on top of the read-data capture.
  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    for (genvar r = 0; r < LANES; r++) begin : g_lane
      localparam int LSB = (g * LANES + LANES - 1 - r) * BIT_WIDTH;

      skew_line #(.WIDTH(BIT_WIDTH), .DEPTH(r)) u_west (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_vld),
        .in_data  (a_rd_data[LSB +: BIT_WIDTH]),
        .out_data (west_feed[g][LANES-1-r])
      );

      skew_line #(.WIDTH(BIT_WIDTH), .DEPTH(r)) u_north (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_vld),
        .in_data  (b_rd_data[LSB +: BIT_WIDTH]),
        .out_data (north_feed[g][LANES-1-r])
      );
    end
  end

  assign west_in0  = west_feed[0];
  assign west_in1  = west_feed[1];
  assign west_in2  = west_feed[2];
  assign west_in3  = west_feed[3];
  assign west_in4  = west_feed[4];
  assign west_in5  = west_feed[5];
  assign west_in6  = west_feed[6];
  assign west_in7  = west_feed[7];
  assign north_in0 = north_feed[0];
  assign north_in1 = north_feed[1];
  assign north_in2 = north_feed[2];
  assign north_in3 = north_feed[3];
  assign north_in4 = north_feed[4];
  assign north_in5 = north_feed[5];
  assign north_in6 = north_feed[6];
  assign north_in7 = north_feed[7];

endmodule

// File: tb/tb_block_mm_sched.sv
// Directed bench for block_mm_sched: job-level reference model, per-cycle compare,
// and hand-computed literal expectations.
module tb_block_mm_sched;

  localparam int BW = 16;
  localparam int FW = 8;
  localparam int RW = 4 * BW;
  localparam int MW = 32 * BW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic res_ready = 1'b1;
  logic dp_done = 1'b0;
  logic busy, rd_en, dp_rst_n, res_valid, err;
  logic [1:0] rd_addr;
  logic [MW-1:0] a_rd_data = '0;
  logic [MW-1:0] b_rd_data = '0;
  logic [RW-1:0] west [8];
  logic [RW-1:0] north [8];
  logic [RW-1:0] dp_row [4];
  logic [RW-1:0] res_row [4];
  block_mm_pkg::state_t state;

  always #5 clk = ~clk;

  block_mm_sched #(.BIT_WIDTH(BW), .FRAC_WIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .dp_rst_n(dp_rst_n),
    .west_in0(west[0]), .west_in1(west[1]), .west_in2(west[2]), .west_in3(west[3]),
    .west_in4(west[4]), .west_in5(west[5]), .west_in6(west[6]), .west_in7(west[7]),
    .north_in0(north[0]), .north_in1(north[1]), .north_in2(north[2]), .north_in3(north[3]),
    .north_in4(north[4]), .north_in5(north[5]), .north_in6(north[6]), .north_in7(north[7]),
    .dp_row0(dp_row[0]), .dp_row1(dp_row[1]), .dp_row2(dp_row[2]), .dp_row3(dp_row[3]),
    .dp_done(dp_done),
    .res_row0(res_row[0]), .res_row1(res_row[1]), .res_row2(res_row[2]), .res_row3(res_row[3]),
    .res_valid(res_valid), .res_ready(res_ready), .err(err), .state(state)
  );

  // Operand memory: registered read, data one cycle after rd_en.
  logic [MW-1:0] mem_a [4];
  logic [MW-1:0] mem_b [4];

  always @(posedge clk) begin
    if (rd_en) begin
      a_rd_data <= mem_a[rd_addr];
      b_rd_data <= mem_b[rd_addr];
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level reference model ----------------
  // Tracks the job by its start cycle; all outputs follow from offsets to it.
  int cyc = 0;
  bit m_busy = 1'b0;
  bit m_out = 1'b0;
  int m_s = 0;
  bit chk_en = 1'b0;
  logic [RW-1:0] m_res [4];

  always @(posedge clk) begin : model_p
    int old;
    old = cyc;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_out  = 1'b0;
      for (int i = 0; i < 4; i++) m_res[i] = '0;
      chk_en = 1'b1;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_s    = old;
      end
    end else if (m_out) begin
      if (res_ready) begin
        m_busy = 1'b0;
        m_out  = 1'b0;
      end
    end else if (old >= m_s + 10) begin
      if (dp_done) begin
        m_out = 1'b1;
        for (int i = 0; i < 4; i++) m_res[i] = dp_row[i];
      end
`ifdef BLOCK_MM_SCHED_TIMEOUT_EN
      else if (old - m_s - 10 == 30) m_busy = 1'b0;
`endif
    end
  end

  function automatic logic [RW-1:0] elem_at(input bit is_north, input int k, input int g, input int lane);
    logic [MW-1:0] w;
    w = is_north ? mem_b[k] : mem_a[k];
    return {48'b0, w[(g*4 + 3 - lane)*BW +: BW]};
  endfunction

  function automatic logic [RW-1:0] exp_feed(input bit is_north, input int g);
    logic [RW-1:0] v;
    logic [RW-1:0] e;
    int t;
    v = '0;
    for (int r = 0; r < 4; r++) begin
      t = cyc - m_s - 3 - r;
      if (m_busy && !m_out && t >= 0 && t <= 3) begin
        e = elem_at(is_north, t, g, r);
        v[(3-r)*BW +: BW] = e[BW-1:0];
      end
    end
    return v;
  endfunction

  function automatic logic exp_err();
`ifdef BLOCK_MM_SCHED_TIMEOUT_EN
    return m_busy && !m_out && (cyc - m_s - 10 == 30) && !dp_done;
`else
    return 1'b0;
`endif
  endfunction

  // Stand-in datapath: C = A*B over 8 groups x 4 K, rescaled by FW fractional bits.
  function automatic logic [RW-1:0] calc_row(input int i);
    logic signed [47:0] acc;
    logic signed [BW-1:0] a, b;
    logic [RW-1:0] row;
    logic [RW-1:0] ea, eb;
    row = '0;
    for (int j = 0; j < 4; j++) begin
      acc = '0;
      for (int g = 0; g < 8; g++)
        for (int k = 0; k < 4; k++) begin
          ea = elem_at(1'b0, k, g, i);
          eb = elem_at(1'b1, k, g, j);
          a = ea[BW-1:0];
          b = eb[BW-1:0];
          acc = acc + a * b;
        end
      row[(3-j)*BW +: BW] = BW'(acc >>> FW);
    end
    return row;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("dp_rst_n", dp_rst_n, m_busy && !m_out);
      chk("rd_en", rd_en, m_busy && !m_out && (cyc - m_s >= 1) && (cyc - m_s <= 4));
      if (m_busy && !m_out && (cyc - m_s >= 1) && (cyc - m_s <= 4))
        chk("rd_addr", rd_addr, 64'(cyc - m_s - 1));
      chk("res_valid", res_valid, m_out);
      if (m_out)
        for (int i = 0; i < 4; i++) chk("res_row", res_row[i], m_res[i]);
      for (int g = 0; g < 8; g++) begin
        chk("west_in", west[g], exp_feed(1'b0, g));
        chk("north_in", north[g], exp_feed(1'b1, g));
      end
      chk("err", err, exp_err());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic start_job(output int s);
    for (int i = 0; i < 4; i++) dp_row[i] = calc_row(i);
    start = 1'b1;
    s = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic complete(input int s, input int d);
    wait_cyc(s + 10 + d);
    dp_done = 1'b1;
    tick(1);
    dp_done = 1'b0;
    for (int i = 0; i < 4; i++) dp_row[i] = ~dp_row[i];
    for (int i = 0; i < 50 && busy; i++) tick(1);
    chk("job_end", busy, 1'b0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 32; w++) begin
        mem_a[k][w*BW +: BW] = BW'($urandom_range(0, 16'hffff));
        mem_b[k][w*BW +: BW] = BW'($urandom_range(0, 16'hffff));
      end
  endtask

  // ---------------- directed tests ----------------
  initial begin : test_p
    int s, s2;
    logic [RW-1:0] held;
    bit seen_valid;

    for (int i = 0; i < 4; i++) dp_row[i] = '0;
    fill_random();

    // Reset held for 3 cycles.
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_dp_rst_n", dp_rst_n, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_res_row0", res_row[0], 64'h0);
    chk("rst_west0", west[0], 64'h0);
    tick(2);

    // Skew: group 0 element (lane r, K k) = 16*r + k on both operands.
    fill_random();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++) begin
        mem_a[k][(3-r)*BW +: BW] = BW'(16*r + k);
        mem_b[k][(3-r)*BW +: BW] = BW'(16*r + k);
      end
    start_job(s);
    chk("skew_dp_rst_n_s1", dp_rst_n, 1'b1);
    wait_cyc(s + 3);
    chk("skew_w0_s3", west[0], 64'h0000_0000_0000_0000);
    wait_cyc(s + 4);
    chk("skew_rd_addr_s4", rd_addr, 2'd3);
    chk("skew_w0_s4", west[0], 64'h0001_0010_0000_0000);
    wait_cyc(s + 6);
    chk("skew_n0_s6", north[0], 64'h0003_0012_0021_0030);
    wait_cyc(s + 9);
    chk("skew_w0_s9", west[0], 64'h0000_0000_0000_0033);
    chk("skew_n0_s9", north[0], 64'h0000_0000_0000_0033);
    wait_cyc(s + 10);
    chk("skew_w0_s10", west[0], 64'h0);
    chk("skew_busy_wait", busy, 1'b1);
    complete(s, 2);

    // All elements 1.0: every result element is 32 * 1.0 = 0x2000.
    for (int k = 0; k < 4; k++) begin
      mem_a[k] = {32{16'h0100}};
      mem_b[k] = {32{16'h0100}};
    end
    start_job(s);
    wait_cyc(s + 15);
    dp_done = 1'b1;
    tick(1);
    dp_done = 1'b0;
    chk("ones_res_valid", res_valid, 1'b1);
    chk("ones_busy_out", busy, 1'b1);
    chk("ones_row0", res_row[0], {4{16'h2000}});
    chk("ones_row3", res_row[3], {4{16'h2000}});
    chk("ones_dp_rst_n_out", dp_rst_n, 1'b0);
    tick(1);
    chk("ones_busy_after", busy, 1'b0);

    // Backpressure with start pulsed during OUT.
    fill_random();
    res_ready = 1'b0;
    start_job(s);
    held = dp_row[0];
    wait_cyc(s + 13);
    dp_done = 1'b1;
    tick(1);
    dp_done = 1'b0;
    for (int i = 0; i < 4; i++) dp_row[i] = ~dp_row[i];
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick(1);
      chk("bp_hold_row0", res_row[0], held);
      chk("bp_valid", res_valid, 1'b1);
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick(1);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_valid", res_valid, 1'b0);
    fill_random();
    start_job(s2);
    chk("bp_restart_busy", busy, 1'b1);
    complete(s2, 0);

    // WAIT with dp_done never asserted.
    fill_random();
    start_job(s);
    seen_valid = 1'b0;
`ifdef BLOCK_MM_SCHED_TIMEOUT_EN
    while (cyc < s + 40) begin
      seen_valid |= res_valid;
      chk("to_no_err_early", err, 1'b0);
      tick(1);
    end
    chk("to_err_pulse", err, 1'b1);
    chk("to_busy_last", busy, 1'b1);
    tick(1);
    chk("to_err_drop", err, 1'b0);
    chk("to_idle", busy, 1'b0);
    chk("to_dp_rst_n", dp_rst_n, 1'b0);
    chk("to_no_result", seen_valid, 1'b0);
`else
    while (cyc < s + 110) begin
      seen_valid |= res_valid;
      tick(1);
    end
    chk("nto_still_busy", busy, 1'b1);
    chk("nto_dp_rst_n", dp_rst_n, 1'b1);
    chk("nto_err", err, 1'b0);
    chk("nto_no_result", seen_valid, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("nto_reset_idle", busy, 1'b0);
`endif
    tick(2);

    // Reset pulse mid-WAIT, then a fresh job.
    fill_random();
    start_job(s);
    wait_cyc(s + 13);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_dp_rst_n", dp_rst_n, 1'b0);
    chk("mr_res_valid", res_valid, 1'b0);
    chk("mr_res_row0", res_row[0], 64'h0);
    tick(1);
    fill_random();
    start_job(s2);
    complete(s2, 3);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
